// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Brief    : Requester and memory-side signal bundle for the data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              m0_req;
    logic [DW/8-1:0]   m0_wa;
    logic [AW-1:0]     m0_addr;
    logic [DW-1:0]     m0_wdata;
    logic              m0_ack;
    logic [DW-1:0]     m0_rdata;

    logic              m1_req;
    logic [DW/8-1:0]   m1_wa;
    logic [AW-1:0]     m1_addr;
    logic [DW-1:0]     m1_wdata;
    logic              m1_ack;
    logic [DW-1:0]     m1_rdata;

    logic [DW/8-1:0]   mem_wa;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;

    logic              busy;
    logic              owner;

    // Arbiter side
    modport slave (
        input  m0_req, m0_wa, m0_addr, m0_wdata,
        output m0_ack, m0_rdata,
        input  m1_req, m1_wa, m1_addr, m1_wdata,
        output m1_ack, m1_rdata,
        output mem_wa, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy, owner
    );

    // Requester / memory-model side
    modport master (
        output m0_req, m0_wa, m0_addr, m0_wdata,
        input  m0_ack, m0_rdata,
        output m1_req, m1_wa, m1_addr, m1_wdata,
        input  m1_ack, m1_rdata,
        input  mem_wa, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy, owner
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-master data-memory arbiter, m0 priority with m1 anti-starvation.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_LIM = 4
) (
    input  wire logic      clk,
    input  wire logic      rst,
    dmem_arbiter_if.slave  bus
);

    localparam int         c_bw    = DW / 8;
    localparam logic [3:0] c_lim   = 4'(STARVE_LIM);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_grant = 2'd1;
    localparam logic [1:0] c_resp  = 2'd2;

    logic [1:0]      r_state;
    logic [3:0]      r_starve;
    logic            r_owner;
    logic            r_busy;
    logic [c_bw-1:0] r_wa;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_m0_rdata;
    logic [DW-1:0]   r_m1_rdata;
    logic            r_m0_ack;
    logic            r_m1_ack;

    logic [1:0]      w_next;
    logic            w_start;
    logic            w_grant_m1;
    logic [3:0]      w_starve_next;
    logic [c_bw-1:0] w_mem_wa;

    always_comb begin
        w_next        = r_state;
        w_start       = 1'b0;
        w_grant_m1    = 1'b0;
        w_starve_next = r_starve;
        case (r_state)
            c_idle: begin
                if (bus.m0_req || bus.m1_req) begin
                    w_start = 1'b1;
                    w_next  = c_grant;
                    if (bus.m0_req && bus.m1_req) begin
                        if (r_starve == c_lim) begin
                            w_grant_m1    = 1'b1;
                            w_starve_next = 4'd0;
                        end else begin
                            w_starve_next = r_starve + 4'd1;
                        end
                    end else if (bus.m1_req) begin
                        w_grant_m1    = 1'b1;
                        w_starve_next = 4'd0;
                    end
                end
            end
            c_grant: w_next = c_resp;
            c_resp:  w_next = c_idle;
            default: w_next = c_idle;
        endcase
    end

    // Write enables are gated by rst directly so a reset landing on GRANT never commits.
    always_comb begin
        w_mem_wa = '0;
        if (r_state == c_grant && !rst) begin
            w_mem_wa = r_wa;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_idle;
            r_starve   <= 4'd0;
            r_owner    <= 1'b0;
            r_busy     <= 1'b0;
            r_wa       <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
            r_m0_ack   <= 1'b0;
            r_m1_ack   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_starve <= w_starve_next;
            r_busy   <= (w_next != c_idle);
            if (w_start) begin
                r_owner <= w_grant_m1;
                r_wa    <= w_grant_m1 ? bus.m1_wa    : bus.m0_wa;
                r_addr  <= w_grant_m1 ? bus.m1_addr  : bus.m0_addr;
                r_wdata <= w_grant_m1 ? bus.m1_wdata : bus.m0_wdata;
            end
            if (r_state == c_grant && r_wa == '0) begin
                if (r_owner) begin
                    r_m1_rdata <= bus.mem_rdata;
                end else begin
                    r_m0_rdata <= bus.mem_rdata;
                end
            end
            r_m0_ack <= (r_state == c_grant) && !r_owner;
            r_m1_ack <= (r_state == c_grant) &&  r_owner;
        end
    end

    assign bus.mem_wa    = w_mem_wa;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.m0_ack    = r_m0_ack;
    assign bus.m1_ack    = r_m1_ack;
    assign bus.m0_rdata  = r_m0_rdata;
    assign bus.m1_rdata  = r_m1_rdata;
    assign bus.busy      = r_busy;
    assign bus.owner     = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Directed self-checking bench for dmem_arbiter with a byte-lane memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [31:0] mem [0:63];

    dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

    dmem_arbiter #(.AW(32), .DW(32), .STARVE_LIM(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory runs on the falling edge; reads are visible within the same cycle.
    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];
    always @(negedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bus.mem_wa[b]) mem[bus.mem_addr[7:2]][b*8 +: 8] = bus.mem_wdata[b*8 +: 8];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_m1;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4] = 32'hDEADBEEF;
        mem[5] = 32'h11111111;
        mem[8] = 32'h12345678;

        rst = 1'b1;
        bus.m0_req = 1'b0; bus.m0_wa = 4'h0; bus.m0_addr = 32'h0; bus.m0_wdata = 32'h0;
        bus.m1_req = 1'b0; bus.m1_wa = 4'h0; bus.m1_addr = 32'h0; bus.m1_wdata = 32'h0;
        tick();
        tick();
        check("rst_m0_ack",   {31'h0, bus.m0_ack}, 32'h0);
        check("rst_m1_ack",   {31'h0, bus.m1_ack}, 32'h0);
        check("rst_m0_rdata", bus.m0_rdata, 32'h0);
        check("rst_m1_rdata", bus.m1_rdata, 32'h0);
        check("rst_owner",    {31'h0, bus.owner}, 32'h0);
        check("rst_busy",     {31'h0, bus.busy}, 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check("rst_mem_wa",   {28'h0, bus.mem_wa}, 32'h0);
        rst = 1'b0;
        tick();

        // Single m0 read
        bus.m0_req = 1'b1; bus.m0_addr = 32'h10; bus.m0_wa = 4'h0;
        tick();
        check("rd0_grant_addr", bus.mem_addr, 32'h10);
        check("rd0_grant_wa",   {28'h0, bus.mem_wa}, 32'h0);
        check("rd0_grant_busy", {31'h0, bus.busy}, 32'h1);
        check("rd0_grant_ack",  {31'h0, bus.m0_ack}, 32'h0);
        tick();
        check("rd0_ack",    {31'h0, bus.m0_ack}, 32'h1);
        check("rd0_m1_ack", {31'h0, bus.m1_ack}, 32'h0);
        check("rd0_rdata",  bus.m0_rdata, 32'hDEADBEEF);
        bus.m0_req = 1'b0;
        tick();
        check("rd0_ack_pulse", {31'h0, bus.m0_ack}, 32'h0);
        check("rd0_idle_busy", {31'h0, bus.busy}, 32'h0);

        // m1 byte-lane write then read-back
        bus.m1_req = 1'b1; bus.m1_wa = 4'b0010; bus.m1_addr = 32'h20; bus.m1_wdata = 32'h0000AB00;
        tick();
        check("wr1_grant_wa", {28'h0, bus.mem_wa}, 32'h2);
        check("wr1_owner",    {31'h0, bus.owner}, 32'h1);
        tick();
        check("wr1_resp_wa", {28'h0, bus.mem_wa}, 32'h0);
        check("wr1_ack",     {31'h0, bus.m1_ack}, 32'h1);
        check("wr1_rdata",   bus.m1_rdata, 32'h0);
        bus.m1_req = 1'b0;
        tick();
        bus.m1_req = 1'b1; bus.m1_wa = 4'h0;
        tick();
        tick();
        check("rb1_ack",   {31'h0, bus.m1_ack}, 32'h1);
        check("rb1_rdata", bus.m1_rdata, 32'h1234AB78);
        bus.m1_req = 1'b0;
        tick();

        // Continuous contention: m1 wins every fifth grant
        bus.m0_req = 1'b1; bus.m0_addr = 32'h10; bus.m0_wa = 4'h0;
        bus.m1_req = 1'b1; bus.m1_addr = 32'h14; bus.m1_wa = 4'h0;
        for (int g = 0; g < 10; g++) begin
            exp_m1 = (g == 4) || (g == 9);
            tick();
            check($sformatf("arb_owner_%0d", g), {31'h0, bus.owner}, {31'h0, exp_m1});
            tick();
            check($sformatf("arb_m0_ack_%0d", g), {31'h0, bus.m0_ack}, {31'h0, !exp_m1});
            check($sformatf("arb_m1_ack_%0d", g), {31'h0, bus.m1_ack}, {31'h0, exp_m1});
            if (g == 9) begin
                bus.m0_req = 1'b0;
                bus.m1_req = 1'b0;
            end
            tick();
        end
        check("arb_m0_rdata", bus.m0_rdata, 32'hDEADBEEF);
        check("arb_m1_rdata", bus.m1_rdata, 32'h11111111);

        // Address change after the IDLE sample is ignored
        mem[4] = 32'hCAFEF00D;
        bus.m0_req = 1'b1; bus.m0_addr = 32'h10;
        tick();
        bus.m0_addr = 32'h14;
        #1;
        check("late_addr", bus.mem_addr, 32'h10);
        tick();
        check("late_rdata", bus.m0_rdata, 32'hCAFEF00D);
        bus.m0_req = 1'b0;
        tick();

        // Reset landing on the GRANT cycle of an m1 full-word write
        bus.m1_req = 1'b1; bus.m1_wa = 4'hF; bus.m1_addr = 32'h20; bus.m1_wdata = 32'hFFFFFFFF;
        tick();
        rst = 1'b1;
        #1;
        check("rstg_mem_wa", {28'h0, bus.mem_wa}, 32'h0);
        bus.m1_req = 1'b0;
        tick();
        rst = 1'b0;
        check("rstg_m1_ack",   {31'h0, bus.m1_ack}, 32'h0);
        check("rstg_busy",     {31'h0, bus.busy}, 32'h0);
        check("rstg_owner",    {31'h0, bus.owner}, 32'h0);
        check("rstg_mem_addr", bus.mem_addr, 32'h0);
        check("rstg_wdata",    bus.mem_wdata, 32'h0);
        check("rstg_m0_rdata", bus.m0_rdata, 32'h0);
        check("rstg_m1_rdata", bus.m1_rdata, 32'h0);
        check("rstg_mem_word", mem[8], 32'h1234AB78);
        tick();
        check("rstg_no_ack", {31'h0, bus.m1_ack}, 32'h0);

        // Quiet bus
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("idle_busy_%0d", c),   {31'h0, bus.busy}, 32'h0);
            check($sformatf("idle_wa_%0d", c),     {28'h0, bus.mem_wa}, 32'h0);
            check($sformatf("idle_m0_ack_%0d", c), {31'h0, bus.m0_ack}, 32'h0);
            check($sformatf("idle_m1_ack_%0d", c), {31'h0, bus.m1_ack}, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
